// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte TX FIFO.
// Register window (8 bytes at BASE_ADDR): +0 TXDATA (write pushes a byte), +4 STATUS.
// Optional feature macro: UART_TX_IRQ_EN adds the irq output and STATUS.ie (bit 9).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MemWrite_EN,
    input  logic [31:0] MemAddr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        mmio_sel,
`ifdef UART_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        uart_txd
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Bus decode
    logic hit;
    logic push_req;
    logic push_ok;
    logic stat_wr;
    logic ovf_set;

    // FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;

    // TX engine
    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_cnt_nxt;
    logic [7:0]        shift;
    logic [7:0]        shift_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_nxt;
    logic              txd_nxt;
    logic              pop;
    logic              bit_end;

    logic        ovf;
    logic [31:0] status;

    // Bits of the bus that this block does not decode
    logic unused_bus_bits;
    assign unused_bus_bits = &{1'b0, MemAddr[1:0], MemWrite_EN[3:1], WriteData[31:8]};

    // Address window decode and write qualification
    assign hit        = (MemAddr[31:3] == BASE_ADDR[31:3]);
    assign push_req   = hit && !MemAddr[2] && MemWrite_EN[0];
    assign stat_wr    = hit && MemAddr[2] && MemWrite_EN[0];
    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && !push_ok;
    assign bit_end    = (baud_cnt == '0);

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // TX FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // TX FSM next state, baud timing, shifter and line level
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        shift_nxt    = shift;
        bit_idx_nxt  = bit_idx;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_nxt    = fifo_mem[rd_ptr];
                    baud_cnt_nxt = BAUD_RELOAD;
                    state_nxt    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_nxt = BAUD_RELOAD;
                    bit_idx_nxt  = 3'd0;
                    state_nxt    = ST_DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_nxt = BAUD_RELOAD;
                    shift_nxt    = {1'b0, shift[7:1]};
                    bit_idx_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_nxt = ST_IDLE;
                end else begin
                    baud_cnt_nxt = baud_cnt - BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered so uart_txd stays registered
        case (state_nxt)
            ST_START: txd_nxt = 1'b0;
            ST_DATA:  txd_nxt = shift_nxt[0];
            default:  txd_nxt = 1'b1;
        endcase
    end

    // TX datapath registers and serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            uart_txd <= 1'b1;
        end else begin
            baud_cnt <= baud_cnt_nxt;
            shift    <= shift_nxt;
            bit_idx  <= bit_idx_nxt;
            uart_txd <= txd_nxt;
        end
    end

    // Sticky overflow flag; a same-cycle overflow beats the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (stat_wr && WriteData[3]) begin
            ovf <= 1'b0;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic ie;

    // Interrupt enable and registered "transmitter drained" interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (hit && MemAddr[2] && MemWrite_EN[1]) begin
                ie <= WriteData[9];
            end
            irq <= ie && fifo_empty && (state == ST_IDLE);
        end
    end
`endif

    // STATUS register image (pre-write state)
    always_comb begin
        status      = '0;
        status[0]   = fifo_full;
        status[1]   = fifo_empty;
        status[2]   = (state != ST_IDLE);
        status[3]   = ovf;
        status[8:4] = 5'(fifo_cnt);
`ifdef UART_TX_IRQ_EN
        status[9]   = ie;
`endif
    end

    // Registered read port, one-cycle latency like the data BRAM
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadData <= '0;
            mmio_sel <= 1'b0;
        end else begin
            mmio_sel <= hit;
            ReadData <= (hit && MemAddr[2]) ? status : '0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx (BAUD_DIV=4, FIFO_DEPTH=16).
// Bytes written to TXDATA are queued as expectations and checked against decoded frames.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned B     = 4;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MemWrite_EN;
    logic [31:0] MemAddr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        mmio_sel;
    logic        uart_txd;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q [$];
    logic       samp [128];

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .BAUD_DIV   (B),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite_EN (MemWrite_EN),
        .MemAddr     (MemAddr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .mmio_sel    (mmio_sel),
`ifdef UART_TX_IRQ_EN
        .irq         (irq),
`endif
        .uart_txd    (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        MemAddr     = 32'h0;
        WriteData   = 32'h0;
        MemWrite_EN = 4'h0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
        MemAddr     = a;
        WriteData   = d;
        MemWrite_EN = en;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] rd, output logic sel);
        MemAddr     = a;
        MemWrite_EN = 4'h0;
        @(negedge clk);
        rd  = ReadData;
        sel = mmio_sel;
        drive_idle();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        sel;
        reset = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (uart_txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", uart_txd); else n_pass++;
        n_checks++;
        if (mmio_sel !== 1'b0 || ReadData !== 32'h0)
            $display("FAIL reset_read: got sel=%b rd=%h want sel=0 rd=0", mmio_sel, ReadData);
        else n_pass++;
`ifdef UART_TX_IRQ_EN
        n_checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
`endif
        do_read(BASE + 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0000_0002 || sel !== 1'b1)
            $display("FAIL reset_status: got rd=%h sel=%b want rd=00000002 sel=1", rd, sel);
        else n_pass++;
        do_read(BASE, rd, sel);
        n_checks++;
        if (rd !== 32'h0 || sel !== 1'b1)
            $display("FAIL txdata_read: got rd=%h sel=%b want rd=00000000 sel=1", rd, sel);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [7:0] exp;
        logic [7:0] got;
        logic       lvl;
        logic       ok;
        int         s;
        exp_q.push_back(8'hA5);
        do_write(BASE, 32'hFFFF_FFA5, 4'h1);
        for (int i = 0; i < 60; i++) begin
            samp[i] = uart_txd;
            if (i == 9) begin
                n_checks++;
                if (ReadData !== 32'h0000_0006 || mmio_sel !== 1'b1)
                    $display("FAIL busy_status: got rd=%h sel=%b want rd=00000006 sel=1", ReadData, mmio_sel);
                else n_pass++;
                drive_idle();
            end
            if (i == 8) MemAddr = BASE + 32'h4;
            @(negedge clk);
        end
        s = -1;
        for (int i = 0; i < 60; i++) if (samp[i] === 1'b0 && s < 0) s = i;
        n_checks++;
        if (s != 1) $display("FAIL frame_start: got index %0d want 1", s); else n_pass++;
        if (s >= 0 && s <= 19) begin
            exp = exp_q.pop_front();
            got = '0;
            for (int b = 0; b < 10; b++) begin
                lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
                ok  = 1'b1;
                for (int j = 0; j < 4; j++) if (samp[s + 4*b + j] !== lvl) ok = 1'b0;
                n_checks++;
                if (!ok)
                    $display("FAIL a5_level%0d: got %b%b%b%b want 4x%b", b, samp[s+4*b],
                             samp[s+4*b+1], samp[s+4*b+2], samp[s+4*b+3], lvl);
                else n_pass++;
            end
            for (int b = 0; b < 8; b++) got[b] = samp[s + 4 + 4*b + 2];
            n_checks++;
            if (got !== exp) $display("FAIL a5_byte: got %h want %h", got, exp); else n_pass++;
            n_checks++;
            if (samp[s + 40] !== 1'b1) $display("FAIL a5_idle: got %b want 1", samp[s+40]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        logic [7:0] got;
        logic       ok_start;
        logic       ok_stop;
        int         s;
        int         prev;
        int         from;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        do_write(BASE, 32'h11, 4'h1);
        do_write(BASE, 32'h22, 4'h1);
        for (int i = 0; i < 110; i++) begin
            samp[i] = uart_txd;
            @(negedge clk);
        end
        from = 0;
        prev = 0;
        for (int k = 0; k < 2; k++) begin
            s = -1;
            for (int i = from; i < 70; i++) if (samp[i] === 1'b0 && s < 0) s = i;
            n_checks++;
            if (s < 0) begin
                $display("FAIL b2b_frame%0d_found: got none want start bit", k);
                break;
            end
            n_pass++;
            if (k == 1) begin
                n_checks++;
                if (s - prev != 41) $display("FAIL b2b_spacing: got %0d want 41", s - prev); else n_pass++;
            end
            ok_start = 1'b1;
            ok_stop  = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (samp[s + j] !== 1'b0) ok_start = 1'b0;
                if (samp[s + 36 + j] !== 1'b1) ok_stop = 1'b0;
            end
            for (int b = 0; b < 8; b++) got[b] = samp[s + 4 + 4*b + 2];
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok_start || !ok_stop || got !== exp)
                $display("FAIL b2b_frame%0d: got byte=%h start_ok=%b stop_ok=%b want byte=%h start_ok=1 stop_ok=1",
                         k, got, ok_start, ok_stop, exp);
            else n_pass++;
            prev = s;
            from = s + 40;
        end
    endtask

    task automatic test_fill_ovf();
        logic [31:0] rd;
        logic        sel;
        // First byte is popped by the idle transmitter, so 17 writes leave 16 queued
        for (int i = 0; i < 17; i++) do_write(BASE, 32'(i), 4'h1);
        do_read(BASE + 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0000_0105) $display("FAIL fill_full: got %h want 00000105", rd); else n_pass++;
        do_write(BASE, 32'hEE, 4'h1);
        do_read(BASE + 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0000_010D) $display("FAIL fill_ovf: got %h want 0000010d", rd); else n_pass++;
        do_write(BASE + 32'h4, 32'h8, 4'h1);
        do_read(BASE + 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0000_0105) $display("FAIL ovf_clear: got %h want 00000105", rd); else n_pass++;
        do_write(BASE, 32'hAB, 4'hE);
        do_read(BASE + 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0000_0105) $display("FAIL lane0_only: got %h want 00000105", rd); else n_pass++;
        apply_reset();
    endtask

    task automatic test_outside_window();
        logic [31:0] rd;
        logic        sel;
        do_read(BASE + 32'h8, rd, sel);
        n_checks++;
        if (rd !== 32'h0 || sel !== 1'b0)
            $display("FAIL outside_read_hi: got rd=%h sel=%b want rd=0 sel=0", rd, sel);
        else n_pass++;
        do_read(BASE - 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0 || sel !== 1'b0)
            $display("FAIL outside_read_lo: got rd=%h sel=%b want rd=0 sel=0", rd, sel);
        else n_pass++;
        do_write(BASE + 32'h8, 32'hFF, 4'hF);
        do_write(BASE + 32'hC, 32'hFF, 4'hF);
        do_read(BASE + 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0000_0002) $display("FAIL outside_write: got %h want 00000002", rd); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        logic        sel;
        int          lows;
        do_write(BASE, 32'h3C, 4'h1);
        do_write(BASE, 32'h55, 4'h1);
        do_write(BASE, 32'h66, 4'h1);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (uart_txd !== 1'b1) $display("FAIL midreset_txd: got %b want 1", uart_txd); else n_pass++;
        reset = 1'b0;
        do_read(BASE + 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0000_0002) $display("FAIL midreset_status: got %h want 00000002", rd); else n_pass++;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (uart_txd !== 1'b1) lows++;
            @(negedge clk);
        end
        n_checks++;
        if (lows != 0) $display("FAIL midreset_quiet: got %0d low cycles want 0", lows); else n_pass++;
    endtask

`ifdef UART_TX_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd;
        logic        sel;
        int          rise;
        do_write(BASE + 32'h4, 32'h200, 4'h2);
        do_read(BASE + 32'h4, rd, sel);
        n_checks++;
        if (rd !== 32'h0000_0202 || irq !== 1'b1)
            $display("FAIL irq_enable: got rd=%h irq=%b want rd=00000202 irq=1", rd, irq);
        else n_pass++;
        do_write(BASE, 32'h81, 4'h1);
        rise = -1;
        for (int i = 0; i < 60; i++) begin
            samp[i] = irq;
            if (i >= 1 && irq === 1'b1 && rise < 0) rise = i;
            @(negedge clk);
        end
        n_checks++;
        if (samp[1] !== 1'b0 || rise != 42)
            $display("FAIL irq_frame: got drop=%b rise=%0d want drop=0 rise=42", samp[1], rise);
        else n_pass++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fill_ovf();
        test_outside_window();
        test_reset_mid_frame();
`ifdef UART_TX_IRQ_EN
        test_irq();
`endif
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
